// File: rtl/fpu_add_issue.sv
// ============================================================================
//  Module   : fpu_add_issue (with helper fpu_add_core)
//  Purpose  : Sequenced issue/result stage around a combinational IEEE-754
//             adder. Requests are taken over valid/ready, subtract is folded
//             into B's sign, NaN/Inf/zero operands are screened, and the
//             registered result is held until the consumer takes it.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready, in_a, in_b, in_sub      - request side
//             out_valid/out_ready, out_result,
//             out_overflow, out_underflow, out_invalid   - result side
//             busy                                       - FSM not idle
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Combinational round-to-nearest-even adder. Subnormal inputs are taken at
// face value; results whose normalised exponent falls below 1 are reported
// as underflow, results that round past the largest exponent as overflow.
module fpu_add_core #(
   parameter int X = 32
) (
   input  logic [X-1:0] a,
   input  logic [X-1:0] b,
   output logic [X-1:0] result,
   output logic         overflow,
   output logic         underflow
);
   localparam int EW   = (X == 64) ? 11 : 8;
   localparam int MW   = (X == 64) ? 52 : 23;
   localparam int GW   = MW + 4;          // hidden + fraction + guard/round/sticky
   localparam int EMAX = (1 << EW) - 1;

   logic          a_big, eff_sub, sign_l, sticky;
   logic [EW-1:0] exp_a, exp_b, exp_l, exp_s, diff;
   logic [MW:0]   sig_a, sig_b, sig_l, sig_s;
   logic [GW-1:0] ext_s, aligned, norm;
   logic [GW:0]   sum;
   logic [MW+1:0] rounded;
   logic [MW-1:0] frac;
   logic          rnd;
   int            lz, exp_n, exp_r;

   always_comb begin
      // Subnormals carry an effective exponent of 1 and no hidden bit.
      exp_a = (a[X-2:MW] == '0) ? EW'(1) : a[X-2:MW];
      exp_b = (b[X-2:MW] == '0) ? EW'(1) : b[X-2:MW];
      sig_a = {|a[X-2:MW], a[MW-1:0]};
      sig_b = {|b[X-2:MW], b[MW-1:0]};
      a_big = (a[X-2:0] >= b[X-2:0]);
      sign_l  = a_big ? a[X-1] : b[X-1];
      exp_l   = a_big ? exp_a : exp_b;
      exp_s   = a_big ? exp_b : exp_a;
      sig_l   = a_big ? sig_a : sig_b;
      sig_s   = a_big ? sig_b : sig_a;
      eff_sub = a[X-1] ^ b[X-1];

      // Align the smaller operand; everything shifted out collapses to sticky.
      diff    = exp_l - exp_s;
      ext_s   = {sig_s, 3'b000};
      sticky  = |(ext_s & ~({GW{1'b1}} << diff));
      aligned = (ext_s >> diff) | {{(GW-1){1'b0}}, sticky};
      sum     = eff_sub ? ({1'b0, sig_l, 3'b000} - {1'b0, aligned})
                        : ({1'b0, sig_l, 3'b000} + {1'b0, aligned});

      lz = 0;
      for (int i = 0; i < GW; i++) begin
         if (sum[i]) lz = GW - 1 - i;
      end

      // Carry out: shift right one, keeping the dropped bit in sticky.
      if (sum[GW]) begin
         norm  = {sum[GW:2], sum[1] | sum[0]};
         exp_n = int'(exp_l) + 1;
      end else begin
         norm  = sum[GW-1:0] << lz;
         exp_n = int'(exp_l) - lz;
      end

      rnd     = norm[2] & (norm[1] | norm[0] | norm[3]);
      rounded = {1'b0, norm[GW-1:3]} + {{(MW+1){1'b0}}, rnd};
      if (rounded[MW+1]) begin
         exp_r = exp_n + 1;
         frac  = rounded[MW:1];
      end else begin
         exp_r = exp_n;
         frac  = rounded[MW-1:0];
      end

      result    = '0;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (sum == '0) begin
         result = '0;                      // exact cancellation gives +0
      end else if (exp_n < 1) begin
         underflow = 1'b1;
         result    = {sign_l, {(X-1){1'b0}}};
      end else if (exp_r >= EMAX) begin
         overflow = 1'b1;
         result   = {sign_l, {EW{1'b1}}, {MW{1'b0}}};
      end else begin
         result = {sign_l, exp_r[EW-1:0], frac};
      end
   end
endmodule

module fpu_add_issue #(
   parameter int X = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [X-1:0] in_a,
   input  logic [X-1:0] in_b,
   input  logic         in_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [X-1:0] out_result,
   output logic         out_overflow,
   output logic         out_underflow,
   output logic         out_invalid,
   output logic         busy
);
   localparam int EW = (X == 64) ? 11 : 8;
   localparam int MW = (X == 64) ? 52 : 23;
   localparam logic [X-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;

   state_t         state_q, state_d;
   logic [X-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
   logic           out_valid_q, out_valid_d;
   logic           ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

   logic [X-1:0]   add_result, scr_result;
   logic           add_ovf, add_unf, scr_ovf, scr_unf, scr_inv;
   logic           a_emax, b_emax, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   fpu_add_core #(.X(X)) u_core (
      .a         (a_q),
      .b         (b_q),
      .result    (add_result),
      .overflow  (add_ovf),
      .underflow (add_unf)
   );

   // Special-operand screen; b_q already carries the subtract sign flip.
   always_comb begin
      a_emax = &a_q[X-2:MW];
      b_emax = &b_q[X-2:MW];
      a_nan  = a_emax & (|a_q[MW-1:0]);
      b_nan  = b_emax & (|b_q[MW-1:0]);
      a_inf  = a_emax & ~(|a_q[MW-1:0]);
      b_inf  = b_emax & ~(|b_q[MW-1:0]);
      a_zero = (a_q[X-2:0] == '0);
      b_zero = (b_q[X-2:0] == '0);

      scr_result = add_result;
      scr_ovf    = 1'b0;
      scr_unf    = 1'b0;
      scr_inv    = 1'b0;
      if (a_nan | b_nan) begin
         scr_result = QNAN;
         scr_inv    = 1'b1;
      end else if (a_inf & b_inf & (a_q[X-1] != b_q[X-1])) begin
         scr_result = QNAN;
         scr_inv    = 1'b1;
      end else if (a_inf) begin
         scr_result = a_q;
      end else if (b_inf) begin
         scr_result = b_q;
      end else if (a_zero & b_zero) begin
         scr_result = {a_q[X-1] & b_q[X-1], {(X-1){1'b0}}};
      end else if (add_ovf) begin
         scr_result = {add_result[X-1], {EW{1'b1}}, {MW{1'b0}}};
         scr_ovf    = 1'b1;
      end else if (add_unf) begin
         scr_result = {add_result[X-1], {(X-1){1'b0}}};
         scr_unf    = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      inv_d       = inv_q;
      in_ready    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = in_a;
               b_d     = {in_b[X-1] ^ in_sub, in_b[X-2:0]};
               state_d = EXEC;
            end
         end
         EXEC: begin
            // Flags are overwritten, never OR-ed, so nothing carries over.
            result_d    = scr_result;
            ovf_d       = scr_ovf;
            unf_d       = scr_unf;
            inv_d       = scr_inv;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         inv_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         inv_q       <= inv_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_result    = result_q;
   assign out_overflow  = ovf_q;
   assign out_underflow = unf_q;
   assign out_invalid   = inv_q;
   assign busy          = (state_q != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_fpu_add_issue.sv
// ============================================================================
//  Module   : tb_fpu_add_issue
//  Purpose  : Self-checking bench for fpu_add_issue (single precision).
//             Directed cases plus randomized operands checked against an
//             exact-arithmetic reference built from the IEEE-754 rules.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_add_issue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_sub;
   logic [31:0] in_a, in_b;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic        out_overflow, out_underflow, out_invalid, busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fpu_add_issue #(.X(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_a          (in_a),
      .in_b          (in_b),
      .in_sub        (in_sub),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_invalid   (out_invalid),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: returns {invalid, overflow, underflow, result}.
   // Finite operands are turned into exact signed integers scaled by a common
   // power of two, summed, then rounded to nearest-even.
   function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] b_in,
                                           input logic sub);
      logic [31:0] b;
      logic        sa, sb, sh, sl, neg;
      int          ea, eb, eh, el, d, base, p, e, sh_amt;
      longint      ma, mb, mh, ml, vh, vl, s, m, q, rem, half, one;
      one = 1;
      b   = {b_in[31] ^ sub, b_in[30:0]};
      sa  = a[31];
      sb  = b[31];
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
         return {3'b100, 32'h7FC00000};
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && sa != sb)
         return {3'b100, 32'h7FC00000};
      if (a[30:23] == 8'hFF) return {3'b000, a};
      if (b[30:23] == 8'hFF) return {3'b000, b};
      if (a[30:0] == 0 && b[30:0] == 0) return {3'b000, sa & sb, 31'b0};
      ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
      eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
      ma = longint'(a[22:0]) + ((a[30:23] != 0) ? (one << 23) : 0);
      mb = longint'(b[22:0]) + ((b[30:23] != 0) ? (one << 23) : 0);
      if (ea >= eb) begin eh = ea; mh = ma; sh = sa; el = eb; ml = mb; sl = sb; end
      else          begin eh = eb; mh = mb; sh = sb; el = ea; ml = ma; sl = sa; end
      d = eh - el;
      if (d > 30) begin
         // Far below the rounding point: only "nonzero or not" matters.
         base = eh - 30; vh = mh << 30; vl = (ml != 0) ? 1 : 0;
      end else begin
         base = el; vh = mh << d; vl = ml;
      end
      s = (sh ? -vh : vh) + (sl ? -vl : vl);
      if (s == 0) return 35'b0;
      neg = (s < 0);
      m   = neg ? -s : s;
      p   = 0;
      for (int i = 0; i < 63; i++) if (m[i]) p = i;
      e = base + p - 23;
      if (e < 1) return {3'b001, neg, 31'b0};
      if (p > 23) begin
         sh_amt = p - 23;
         q      = m >> sh_amt;
         rem    = m - (q << sh_amt);
         half   = one << (sh_amt - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (one << 24)) begin q = q >> 1; e = e + 1; end
      end else begin
         q = m << (23 - p);
      end
      if (e >= 255) return {3'b010, neg, 8'hFF, 23'b0};
      return {3'b000, neg, e[7:0], q[22:0]};
   endfunction

   // One transaction. Entered and left at posedge+1. 'hold' cycles of
   // out_ready=0 with a competing in_valid before the result is taken.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [34:0] e, input int hold);
      int n;
      in_a = a; in_b = b; in_sub = s; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 10) begin @(posedge clk); #1; n++; end
      check("accept_ready", in_ready, 1'b1);
      if (!in_ready) begin in_valid = 1'b0; return; end
      @(posedge clk); #1;                   // request accepted at this edge
      in_valid = 1'b0;
      check("busy_exec", busy, 1'b1);
      check("in_ready_exec", in_ready, 1'b0);
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!out_valid && n < 6);
      check("latency", n, 1);
      check("result", out_result, e[31:0]);
      check("flags", {out_invalid, out_overflow, out_underflow}, e[34:32]);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1'b1);
         check("hold_ready", in_ready, 1'b0);
         check("hold_result", out_result, e[31:0]);
         check("hold_flags", {out_invalid, out_overflow, out_underflow}, e[34:32]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("taken_valid", out_valid, 1'b0);
      check("taken_busy", busy, 1'b0);
      check("taken_ready", in_ready, 1'b1);
   endtask

   function automatic logic [31:0] mk(input int e);
      return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
   endfunction

   logic [31:0] specials [6];
   logic [31:0] ra, rb;
   logic        rs;
   int          cat, ea, acc;

   initial begin
      specials = '{32'h00000000, 32'h80000000, 32'h7F800000,
                   32'hFF800000, 32'h7FC00001, 32'h7F800001};
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", out_result, 32'h0);
      check("rst_flags", {out_invalid, out_overflow, out_underflow}, 3'b000);
      check("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1'b1);

      // Directed cases
      run_op(32'h3FC00000, 32'h40100000, 1'b0, {3'b000, 32'h40700000}, 0);
      run_op(32'h40A00000, 32'h40A00000, 1'b1, {3'b000, 32'h00000000}, 0);
      run_op(32'h7F800000, 32'h7F800000, 1'b1, {3'b100, 32'h7FC00000}, 0);
      run_op(32'h7F000000, 32'h7F000000, 1'b0, {3'b010, 32'h7F800000}, 4);
      // Flags from the previous op must not linger
      run_op(32'h3FC00000, 32'h40100000, 1'b0, {3'b000, 32'h40700000}, 0);

      // Throughput with out_ready tied high: one accept every 3 cycles
      acc = 0; out_ready = 1'b1; in_valid = 1'b1;
      in_a = 32'h3F800000; in_b = 32'h3F800000; in_sub = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      check("throughput", acc, 3);
      check("tput_result", out_result, 32'h40000000);
      repeat (2) @(posedge clk);
      #1;

      // Reset while in EXEC
      in_a = 32'h3FC00000; in_b = 32'h40100000; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pre_rst_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_exec_busy", busy, 1'b0);
      check("rst_exec_valid", out_valid, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      // Reset while holding a result
      in_a = 32'h40A00000; in_b = 32'h3F800000; in_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_hold_valid", out_valid, 1'b0);
      check("rst_hold_busy", busy, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(32'h3FC00000, 32'h40100000, 1'b0, {3'b000, 32'h40700000}, 0);

      // Randomized operands against the reference
      for (int k = 0; k < 300; k++) begin
         cat = $urandom_range(0, 9);
         ea  = $urandom_range(60, 190);
         rs  = 1'($urandom_range(0, 1));
         case (cat)
            0, 1, 2, 3, 4: begin ra = mk(ea); rb = mk(ea + $urandom_range(0, 60) - 30); end
            5: begin ra = mk(ea); rb = mk(ea - 40 - $urandom_range(0, 20)); end
            6: begin
               ra = specials[$urandom_range(0, 5)];
               rb = ($urandom_range(0, 1) == 1) ? specials[$urandom_range(0, 5)] : mk(ea);
            end
            7: begin
               ra = mk(ea); rb = {ra[31], ra[30:0] ^ 31'($urandom_range(0, 255))}; rs = 1'b1;
            end
            8: begin ra = mk(252 + $urandom_range(0, 2)); rb = mk(252 + $urandom_range(0, 2)); end
            default: begin
               ra = mk($urandom_range(1, 3));
               rb = {ra[31], ra[30:0] ^ 31'($urandom_range(1, 65535))}; rs = 1'b1;
            end
         endcase
         if ($urandom_range(0, 1) == 1) begin
            run_op(rb, ra, rs, ref_add(rb, ra, rs), ($urandom_range(0, 7) == 0) ? 2 : 0);
         end else begin
            run_op(ra, rb, rs, ref_add(ra, rb, rs), ($urandom_range(0, 7) == 0) ? 2 : 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
